// File: rtl/des_decrypt_iter.sv
// Iterative DES decryption core: one Feistel round per clock, reverse-order subkeys derived on the fly.
// Define DES_KEY_PARITY_CHK_EN to add the advisory key_err output (odd-parity check on key_in bytes).
module des_decrypt_iter #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [63:0] key_in,
  input  logic [63:0] data_in,
  output logic        busy,
  output logic        done,
  output logic [63:0] data_out
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic        key_err
`endif
);

  localparam int CNT_W = $clog2(NUM_ROUNDS);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // Each S-box row-major: entry index = row*16 + column.
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  // Tables use DES 1-based bit numbers; DES bit k of an N-bit bus sits at index N-k.
  function automatic logic [63:0] perm_ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] perm_fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic logic [55:0] perm_pc1(input logic [63:0] x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
    return y;
  endfunction

  function automatic logic [47:0] perm_pc2(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
    return y;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s_out;
    logic [31:0] y;
    logic [5:0]  six;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    s_out = '0;
    for (int s = 0; s < 8; s++) begin
      six = x[47-6*s -: 6];
      s_out[31-4*s -: 4] = 4'(SBOX[s][{six[5], six[0], six[4:1]}]);
    end
    for (int i = 0; i < 32; i++) y[31-i] = s_out[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    case (amt)
      2'd1:    return {x[0], x[27:1]};
      2'd2:    return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, ROUND, FINISH} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      l_reg, r_reg;
  logic [27:0]      c_reg, d_reg;
  logic [63:0]      ip_data;
  logic [55:0]      pc1_key;
  logic [1:0]       rot_amt;
  logic [27:0]      c_rot, d_rot;
  logic [47:0]      round_key;
  logic [31:0]      f_out;

  assign ip_data = perm_ip(data_in);
  assign pc1_key = perm_pc1(key_in);

  // Round 0 uses C16/D16, which equal the PC1 output; later rounds undo the encryption left shifts.
  always_comb begin
    rot_amt = 2'd2;
    if (cnt == '0)
      rot_amt = 2'd0;
    else if (cnt == CNT_W'(1) || cnt == CNT_W'(8) || cnt == CNT_W'(15))
      rot_amt = 2'd1;
    c_rot     = rotr28(c_reg, rot_amt);
    d_rot     = rotr28(d_reg, rot_amt);
    round_key = perm_pc2({c_rot, d_rot});
    f_out     = feistel(r_reg, round_key);
  end

`ifdef DES_KEY_PARITY_CHK_EN
  logic key_bad;

  always_comb begin
    key_bad = 1'b0;
    for (int b = 0; b < 8; b++) key_bad = key_bad | ~(^key_in[8*b +: 8]);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      l_reg    <= '0;
      r_reg    <= '0;
      c_reg    <= '0;
      d_reg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
`ifdef DES_KEY_PARITY_CHK_EN
      key_err  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            l_reg   <= ip_data[63:32];
            r_reg   <= ip_data[31:0];
            c_reg   <= pc1_key[55:28];
            d_reg   <= pc1_key[27:0];
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= ROUND;
`ifdef DES_KEY_PARITY_CHK_EN
            key_err <= key_bad;
`endif
          end
        end
        ROUND: begin
          l_reg <= r_reg;
          r_reg <= l_reg ^ f_out;
          c_reg <= c_rot;
          d_reg <= d_rot;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_W'(NUM_ROUNDS - 1)) state <= FINISH;
        end
        FINISH: begin
          data_out <= perm_fp({r_reg, l_reg});
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
